// File: rtl/cbd_pkg.sv
// Shared definitions for the cbd down-counter family: state encoding, default width
// and the all-ones preset value.
package cbd_pkg;

  localparam int unsigned CbdWidth = 8;
  localparam logic [CbdWidth-1:0] CbdOnes = '1;

  typedef enum logic {
    StRun,
    StHold
  } cbd_state_e;

endpackage

// File: rtl/cbd8_reload.sv
// Cascadable synchronous down counter with borrow chaining, load, preset and one-shot hold.
// Optional reload register and AR input are enabled by defining CBD_RELOAD_EN.
module cbd8_reload
  import cbd_pkg::*;
#(
  parameter int unsigned WIDTH = CbdWidth
) (
  input  logic             i_clk,
  input  logic             i_cs,
  input  logic             i_sp,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_bi,
`ifdef CBD_RELOAD_EN
  input  logic             i_ar,
`endif
  input  logic             i_os,
  output logic [WIDTH-1:0] o_q,
  output logic             o_bo,
  output logic             o_tcp,
  output logic             o_hld
);

  localparam logic [WIDTH-1:0] Ones = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_tcp;
  cbd_state_e       r_state;
`ifdef CBD_RELOAD_EN
  logic [WIDTH-1:0] r_rld;
`endif

  logic w_dec;
  logic w_zero;
  logic w_uf;

  // Kept to a single AND level so a four-stage borrow ripple stays short.
  assign w_dec  = i_en & i_bi & (r_state == StRun);
  assign w_zero = (r_q == '0);
  assign w_uf   = w_dec & w_zero;

  always_ff @(posedge i_clk) begin
    if (i_cs) begin
      r_q     <= '0;
      r_tcp   <= 1'b0;
      r_state <= StRun;
`ifdef CBD_RELOAD_EN
      r_rld   <= '0;
`endif
    end else begin
      r_tcp <= w_uf;
      if (i_sp) begin
        r_q     <= Ones;
        r_state <= StRun;
      end else if (i_ld) begin
        r_q     <= i_d;
        r_state <= StRun;
`ifdef CBD_RELOAD_EN
        r_rld   <= i_d;
`endif
      end else if (w_dec) begin
        if (!w_zero) begin
          r_q <= r_q - WIDTH'(1);
`ifdef CBD_RELOAD_EN
        end else if (i_ar) begin
          r_q <= r_rld;
`endif
        end else if (i_os) begin
          r_state <= StHold;
        end else begin
          r_q <= Ones;
        end
      end
    end
  end

  assign o_q   = r_q;
  assign o_bo  = w_uf;
  assign o_tcp = r_tcp;
  assign o_hld = (r_state == StHold);

endmodule

// File: tb/tb_cbd8_reload.sv
// Self-checking bench for cbd8_reload: scripted scenarios plus randomized stimulus
// against an integer reference model; also exercises a two-stage borrow chain.
module tb_cbd8_reload;
  import cbd_pkg::*;

`ifdef CBD_RELOAD_EN
  localparam bit HasReload = 1'b1;
`else
  localparam bit HasReload = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       cs = 1'b1, sp = 1'b0, ld = 1'b0, en = 1'b0, bi = 1'b0, ar = 1'b0, os = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       bo, tcp, hld;

  // Two-stage chain: low byte first, its BO drives the high byte's BI.
  logic       c_cs = 1'b1, c_ld = 1'b0, c_en = 1'b0;
  logic [7:0] lo_d = 8'h00, hi_d = 8'h00;
  logic [7:0] lo_q, hi_q;
  logic       lo_bo, hi_bo, lo_tcp, hi_tcp, lo_hld, hi_hld;

  // Reference model state.
  int m_q, m_rld;
  bit m_hold, m_tcp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cbd8_reload #(.WIDTH(8)) u_dut (
    .i_clk(clk), .i_cs(cs), .i_sp(sp), .i_ld(ld), .i_d(d), .i_en(en), .i_bi(bi),
`ifdef CBD_RELOAD_EN
    .i_ar(ar),
`endif
    .i_os(os), .o_q(q), .o_bo(bo), .o_tcp(tcp), .o_hld(hld)
  );

  cbd8_reload #(.WIDTH(8)) u_lo (
    .i_clk(clk), .i_cs(c_cs), .i_sp(1'b0), .i_ld(c_ld), .i_d(lo_d), .i_en(c_en), .i_bi(1'b1),
`ifdef CBD_RELOAD_EN
    .i_ar(1'b0),
`endif
    .i_os(1'b0), .o_q(lo_q), .o_bo(lo_bo), .o_tcp(lo_tcp), .o_hld(lo_hld)
  );

  cbd8_reload #(.WIDTH(8)) u_hi (
    .i_clk(clk), .i_cs(c_cs), .i_sp(1'b0), .i_ld(c_ld), .i_d(hi_d), .i_en(c_en), .i_bi(lo_bo),
`ifdef CBD_RELOAD_EN
    .i_ar(1'b0),
`endif
    .i_os(1'b0), .o_q(hi_q), .o_bo(hi_bo), .o_tcp(hi_tcp), .o_hld(hi_hld)
  );

  function automatic bit model_bo();
    return en && bi && !m_hold && (m_q == 0);
  endfunction

  task automatic apply(input logic a_cs, input logic a_sp, input logic a_ld,
                       input logic [7:0] a_d, input logic a_en, input logic a_bi,
                       input logic a_ar, input logic a_os);
    @(negedge clk);
    cs = a_cs; sp = a_sp; ld = a_ld; d = a_d; en = a_en; bi = a_bi; ar = a_ar; os = a_os;
    #1;
  endtask

  // Advance the model by the rules for one rising edge, then let the DUT take the edge.
  task automatic clock_edge();
    bit uf;
    uf = model_bo();
    if (cs) begin
      m_q = 0; m_rld = 0; m_hold = 0; m_tcp = 0;
    end else begin
      m_tcp = uf;
      if (sp) begin
        m_q = 255; m_hold = 0;
      end else if (ld) begin
        m_q = int'(d); m_rld = int'(d); m_hold = 0;
      end else if (en && bi && !m_hold) begin
        if (m_q > 0) m_q = m_q - 1;
        else if (HasReload && ar) m_q = m_rld;
        else if (os) m_hold = 1;
        else m_q = 255;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 8'h00, 0, 0, 0, 0);
    c_cs = 1'b1;
    clock_edge();
    c_cs = 1'b0;
    n_checks++;
    if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else n_pass++;
    n_checks++;
    if (tcp !== 1'b0 || hld !== 1'b0) $display("FAIL reset_flags: tcp=%b hld=%b want 0 0", tcp, hld);
    else n_pass++;
    apply(0, 0, 0, 8'h00, 1, 1, 0, 0);
    n_checks++;
    if (bo !== 1'b1) $display("FAIL reset_bo: got %b want 1", bo); else n_pass++;
    clock_edge();
    n_checks++;
    if (q !== 8'hFF) $display("FAIL reset_wrap_q: got %h want ff", q); else n_pass++;
    n_checks++;
    if (tcp !== 1'b1) $display("FAIL reset_tcp: got %b want 1", tcp); else n_pass++;
    apply(0, 0, 0, 8'h00, 0, 0, 0, 0);
    clock_edge();
    n_checks++;
    if (tcp !== 1'b0) $display("FAIL reset_tcp_clear: got %b want 0", tcp); else n_pass++;
  endtask

  task automatic test_wrap();
    int exp_q[2]   = '{0, 255};
    int exp_bo[2]  = '{0, 1};
    int exp_tcp[2] = '{0, 1};
    apply(0, 0, 1, 8'h01, 0, 0, 0, 0);
    clock_edge();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 8'h00, 1, 1, 0, 0);
      n_checks++;
      if (bo !== exp_bo[i][0]) $display("FAIL wrap_bo[%0d]: got %b want %0d", i, bo, exp_bo[i]);
      else n_pass++;
      clock_edge();
      n_checks++;
      if (q !== exp_q[i][7:0] || tcp !== exp_tcp[i][0])
        $display("FAIL wrap_q[%0d]: got q=%h tcp=%b want q=%h tcp=%0d", i, q, tcp,
                 exp_q[i][7:0], exp_tcp[i]);
      else n_pass++;
    end
  endtask

`ifdef CBD_RELOAD_EN
  task automatic test_reload();
    int exp_q[4]   = '{2, 1, 0, 3};
    int exp_bo[4]  = '{0, 0, 0, 1};
    int exp_tcp[4] = '{0, 0, 0, 1};
    apply(0, 0, 1, 8'h03, 0, 0, 1, 0);
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 8'h00, 1, 1, 1, 0);
      n_checks++;
      if (bo !== exp_bo[i][0]) $display("FAIL reload_bo[%0d]: got %b want %0d", i, bo, exp_bo[i]);
      else n_pass++;
      clock_edge();
      n_checks++;
      if (q !== exp_q[i][7:0] || tcp !== exp_tcp[i][0])
        $display("FAIL reload_q[%0d]: got q=%h tcp=%b want q=%h tcp=%0d", i, q, tcp,
                 exp_q[i][7:0], exp_tcp[i]);
      else n_pass++;
    end
    apply(0, 0, 0, 8'h00, 0, 0, 0, 0);
    clock_edge();
    n_checks++;
    if (tcp !== 1'b0) $display("FAIL reload_tcp_once: got %b want 0", tcp); else n_pass++;
  endtask
`endif

  task automatic test_oneshot();
    int exp_q[5]   = '{1, 0, 0, 0, 0};
    int exp_hld[5] = '{0, 0, 1, 1, 1};
    int exp_bo[5]  = '{0, 0, 1, 0, 0};
    apply(0, 0, 1, 8'h02, 0, 0, 0, 1);
    clock_edge();
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 8'h00, 1, 1, 0, 1);
      n_checks++;
      if (bo !== exp_bo[i][0]) $display("FAIL oneshot_bo[%0d]: got %b want %0d", i, bo, exp_bo[i]);
      else n_pass++;
      clock_edge();
      n_checks++;
      if (q !== exp_q[i][7:0] || hld !== exp_hld[i][0])
        $display("FAIL oneshot_q[%0d]: got q=%h hld=%b want q=%h hld=%0d", i, q, hld,
                 exp_q[i][7:0], exp_hld[i]);
      else n_pass++;
    end
    apply(0, 1, 0, 8'h00, 0, 0, 0, 0);
    clock_edge();
    n_checks++;
    if (q !== 8'hFF || hld !== 1'b0)
      $display("FAIL oneshot_preset: got q=%h hld=%b want q=ff hld=0", q, hld);
    else n_pass++;
  endtask

  task automatic test_priority();
    apply(0, 1, 1, 8'h55, 1, 1, 0, 0);
    clock_edge();
    n_checks++;
    if (q !== CbdOnes) $display("FAIL prio_sp_over_ld: got %h want ff", q); else n_pass++;
    apply(1, 0, 1, 8'h55, 1, 1, 0, 0);
    clock_edge();
    n_checks++;
    if (q !== 8'h00) $display("FAIL prio_cs_over_ld: got %h want 00", q); else n_pass++;
    apply(0, 0, 1, 8'h40, 1, 1, 0, 0);
    clock_edge();
    n_checks++;
    if (q !== 8'h40) $display("FAIL prio_ld_over_dec: got %h want 40", q); else n_pass++;
  endtask

  task automatic test_chain();
    apply(0, 0, 0, 8'h00, 0, 0, 0, 0);
    c_ld = 1'b1; c_en = 1'b0; lo_d = 8'h00; hi_d = 8'h01;
    clock_edge();
    @(negedge clk);
    c_ld = 1'b0; c_en = 1'b1;
    #1;
    n_checks++;
    if (hi_bo !== 1'b0) $display("FAIL chain_bo_0100: got %b want 0", hi_bo); else n_pass++;
    clock_edge();
    n_checks++;
    if (hi_q !== 8'h00 || lo_q !== 8'hFF)
      $display("FAIL chain_borrow: got %h%h want 00ff", hi_q, lo_q);
    else n_pass++;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (hi_bo !== 1'b0) $display("FAIL chain_bo_early[%0d]: got %b want 0", i, hi_bo);
      else n_pass++;
      clock_edge();
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (hi_q !== 8'h00 || lo_q !== 8'h00 || hi_bo !== 1'b1)
      $display("FAIL chain_bo_zero: got q=%h%h bo=%b want 0000 1", hi_q, lo_q, hi_bo);
    else n_pass++;
    c_en = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] rd;
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) == 0), rd, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      n_checks++;
      if (bo !== model_bo()) $display("FAIL rand_bo[%0d]: got %b want %b", i, bo, model_bo());
      else n_pass++;
      clock_edge();
      n_checks++;
      if (q !== m_q[7:0] || tcp !== m_tcp || hld !== m_hold)
        $display("FAIL rand_state[%0d]: got q=%h tcp=%b hld=%b want q=%h tcp=%b hld=%b",
                 i, q, tcp, hld, m_q[7:0], m_tcp, m_hold);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
`ifdef CBD_RELOAD_EN
    test_reload();
`endif
    test_oneshot();
    test_priority();
    test_chain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
